// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// Consumed by instr_cache and icache_data_array.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  // Address bits [1:0] select a byte within a word and are never used by the cache.
  localparam int BYTE_OFF_W = 2;

  // Widths for the default geometry: 12-bit address, 16 lines, 4 words per line.
  localparam int DEF_OFFSET_W = 2;
  localparam int DEF_INDEX_W  = 4;
  localparam int DEF_TAG_W    = 4;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int tag_w(input int addr_w, input int index_w, input int line_words);
    return addr_w - index_w - $clog2(line_words) - BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
// Contents are deliberately left unreset.
module icache_data_array #(
  parameter int DATA_WIDTH = 32,
  parameter int WADDR_W    = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [WADDR_W-1:0]    waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [WADDR_W-1:0]    raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**WADDR_W];

  // NOTE: storage arrays carry no reset; validity is tracked by separately reset bits,
  // so resetting the words would only cost area and reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with zero-cycle hits and a burst line refill.
// Define ICACHE_STATS_EN to add saturating hit/miss counter outputs.
module instr_cache
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int INDEX_WIDTH = 4,
  parameter int LINE_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic                  cpu_valid_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  output logic                  cpu_en_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
`endif
);

  localparam int OFF_W     = offset_w(LINE_WORDS);
  localparam int TAG_W     = tag_w(ADDR_WIDTH, INDEX_WIDTH, LINE_WORDS);
  localparam int LINE_W    = TAG_W + INDEX_WIDTH;
  localparam int NUM_LINES = 1 << INDEX_WIDTH;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  logic [OFF_W-1:0]       req_off;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   unused_byte_off;

  assign req_off         = cpu_addr_i[BYTE_OFF_W +: OFF_W];
  assign req_idx         = cpu_addr_i[BYTE_OFF_W + OFF_W +: INDEX_WIDTH];
  assign req_tag         = cpu_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign unused_byte_off = ^cpu_addr_i[BYTE_OFF_W-1:0];

  icache_state_t          state_q, state_d;
  logic [OFF_W-1:0]       beat_q, beat_d;
  logic [LINE_W-1:0]      line_q, line_d;          // {tag, index} of the line being refilled
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   flush_pend_q, flush_pend_d;

  logic [TAG_W-1:0]       tag_mem_q [NUM_LINES];
  logic [INDEX_WIDTH-1:0] fill_idx;
  logic [TAG_W-1:0]       fill_tag;
  logic                   data_we, tag_we, hit, miss_start;
  logic [DATA_WIDTH-1:0]  rdata;

  assign fill_idx = line_q[INDEX_WIDTH-1:0];
  assign fill_tag = line_q[LINE_W-1:INDEX_WIDTH];

  icache_data_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .WADDR_W   (INDEX_WIDTH + OFF_W)
  ) u_data (
    .clk    (clk),
    .we_i   (data_we),
    .waddr_i({fill_idx, beat_q}),
    .wdata_i(mem_data_i),
    .raddr_i({req_idx, req_off}),
    .rdata_o(rdata)
  );

  assign hit = cpu_valid_i && (state_q == IDLE) && valid_q[req_idx]
               && (tag_mem_q[req_idx] == req_tag);

  assign cpu_data_o = hit ? rdata : '0;
  assign cpu_en_o   = (state_q == IDLE) && (!cpu_valid_i || hit);
  assign mem_req_o  = (state_q == REFILL);
  assign mem_addr_o = (state_q == REFILL) ? {line_q, beat_q, 2'b00} : '0;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_d       = line_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    miss_start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) valid_d = '0;
        if (cpu_valid_i && !hit) begin
          state_d      = REFILL;
          line_d       = {req_tag, req_idx};
          beat_d       = '0;
          flush_pend_d = 1'b0;
          miss_start   = 1'b1;
        end
      end
      REFILL: begin
        // A flush mid-burst still lets the burst drain, but the line never turns valid.
        if (flush_i) begin
          valid_d      = '0;
          flush_pend_d = 1'b1;
        end
        if (mem_valid_i) begin
          data_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            tag_we  = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
            if (!flush_pend_q && !flush_i) valid_d[fill_idx] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      line_q       <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem_q[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != '1))         hit_count_d  = hit_count_q + 32'd1;
    if (miss_start && (miss_count_q != '1)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: table-driven hit vectors plus directed
// refill, stall, flush and mid-burst reset sequences.
module tb_instr_cache;

  logic        clk;
  logic        rst_n;
  logic [11:0] cpu_addr_i;
  logic        cpu_valid_i;
  logic        flush_i;
  logic [31:0] cpu_data_o;
  logic        cpu_en_o;
  logic        mem_req_o;
  logic [11:0] mem_addr_o;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  instr_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr_i (cpu_addr_i),
    .cpu_valid_i(cpu_valid_i),
    .flush_i    (flush_i),
    .cpu_data_o (cpu_data_o),
    .cpu_en_o   (cpu_en_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_valid_i(mem_valid_i),
    .mem_data_i (mem_data_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count_o (hit_count_o),
    .miss_count_o(miss_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [11:0] addr;
    logic        exp_en;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present a fetch expected to miss: the cycle before the burst starts.
  task automatic fetch_miss(input logic [11:0] addr);
    @(negedge clk);
    cpu_valid_i = 1'b1;
    cpu_addr_i  = addr;
    mem_valid_i = 1'b0;
    flush_i     = 1'b0;
    #1;
    check($sformatf("miss_en@%03h", addr), 32'(cpu_en_o), 32'd0);
    check($sformatf("miss_req@%03h", addr), 32'(mem_req_o), 32'd0);
  endtask

  task automatic fetch_hit(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    cpu_valid_i = 1'b1;
    cpu_addr_i  = addr;
    mem_valid_i = 1'b0;
    flush_i     = 1'b0;
    #1;
    check($sformatf("hit_en@%03h", addr), 32'(cpu_en_o), 32'd1);
    check($sformatf("hit_data@%03h", addr), cpu_data_o, data);
    check($sformatf("hit_req@%03h", addr), 32'(mem_req_o), 32'd0);
  endtask

  // Drive n_beats refill beats; optional stall before stall_beat, flush pulse on flush_beat.
  task automatic refill(input logic [11:0] base, input logic [3:0][31:0] d, input int n_beats,
                        input int stall_beat, input int stall_n, input int flush_beat);
    for (int b = 0; b < n_beats; b++) begin
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          cpu_addr_i  = 12'h3FC;
          mem_valid_i = 1'b0;
          flush_i     = 1'b0;
          #1;
          check($sformatf("stall_addr@%03h", base), 32'(mem_addr_o), 32'(base + 12'(4 * b)));
          check("stall_req", 32'(mem_req_o), 32'd1);
        end
      end
      @(negedge clk);
      cpu_addr_i  = 12'h3FC;  // must be ignored during refill
      mem_valid_i = 1'b1;
      mem_data_i  = d[b];
      flush_i     = (b == flush_beat);
      #1;
      check($sformatf("beat%0d_addr@%03h", b, base), 32'(mem_addr_o), 32'(base + 12'(4 * b)));
      check($sformatf("beat%0d_req", b), 32'(mem_req_o), 32'd1);
      check($sformatf("beat%0d_en", b), 32'(cpu_en_o), 32'd0);
    end
  endtask

  logic [3:0][31:0] d0, d1, d2;
  vec_t vecs [7];

  initial begin
    d0 = {32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013};
    d1 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    d2 = {32'hC3000003, 32'hC2000002, 32'hC1000001, 32'hC0000000};
    vecs[0] = '{1'b1, 12'h004, 1'b1, 32'h00100093};
    vecs[1] = '{1'b1, 12'h008, 1'b1, 32'h00200113};
    vecs[2] = '{1'b1, 12'h00C, 1'b1, 32'h00300193};
    vecs[3] = '{1'b0, 12'h010, 1'b1, 32'h00000000};
    vecs[4] = '{1'b1, 12'h000, 1'b1, 32'h00000013};
    vecs[5] = '{1'b1, 12'h00E, 1'b1, 32'h00300193};
    vecs[6] = '{1'b0, 12'h100, 1'b1, 32'h00000000};

    rst_n       = 1'b0;
    cpu_addr_i  = '0;
    cpu_valid_i = 1'b0;
    flush_i     = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
    #1;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_en", 32'(cpu_en_o), 32'd1);
    check("rst_data", cpu_data_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss on 0x000, refill, hit in the cycle after the last beat.
    fetch_miss(12'h000);
    refill(12'h000, d0, 4, -1, 0, -1);
    fetch_hit(12'h000, 32'h00000013);

    // Back-to-back hits and idle cycles from the vector table.
    foreach (vecs[i]) begin
      @(negedge clk);
      cpu_valid_i = vecs[i].valid;
      cpu_addr_i  = vecs[i].addr;
      mem_valid_i = 1'b0;
      flush_i     = 1'b0;
      #1;
      check($sformatf("vec%0d_en", i), 32'(cpu_en_o), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d_data", i), cpu_data_o, vecs[i].exp_data);
      check($sformatf("vec%0d_req", i), 32'(mem_req_o), 32'd0);
    end

    // Conflict on index 0: 0x100 evicts 0x000, which then misses again.
    fetch_miss(12'h100);
    refill(12'h100, d1, 4, -1, 0, -1);
    fetch_hit(12'h104, 32'hA1A1A1A1);
    fetch_miss(12'h000);
    // mem_valid_i low 3 cycles between beats 1 and 2.
    refill(12'h000, d0, 4, 2, 3, -1);
    fetch_hit(12'h008, 32'h00200113);
    fetch_hit(12'h00C, 32'h00300193);
    fetch_hit(12'h000, 32'h00000013);

    // Flush during beat 2: burst completes, nothing stays valid.
    fetch_miss(12'h010);
    refill(12'h010, d2, 4, -1, 0, 2);
    fetch_miss(12'h000);
    refill(12'h000, d0, 4, -1, 0, -1);
    fetch_miss(12'h010);
    refill(12'h010, d2, 4, -1, 0, -1);
    fetch_hit(12'h014, 32'hC1000001);
    fetch_hit(12'h004, 32'h00100093);

    // Flush in IDLE clears the lines for the next cycle.
    @(negedge clk);
    cpu_valid_i = 1'b0;
    flush_i     = 1'b1;
    #1;
    check("idle_flush_en", 32'(cpu_en_o), 32'd1);
    fetch_miss(12'h014);
    refill(12'h010, d2, 4, -1, 0, -1);
    fetch_hit(12'h018, 32'hC2000002);
    fetch_miss(12'h000);
    refill(12'h000, d0, 4, -1, 0, -1);
    fetch_hit(12'h00C, 32'h00300193);

    // Reset during beat 2 drops the burst immediately and invalidates everything.
    fetch_miss(12'h100);
    refill(12'h100, d1, 2, -1, 0, -1);
    @(negedge clk);
    mem_valid_i = 1'b0;
    cpu_addr_i  = 12'h000;
    rst_n       = 1'b0;
    #1;
    check("midrst_req", 32'(mem_req_o), 32'd0);
    check("midrst_addr", 32'(mem_addr_o), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    cpu_valid_i = 1'b0;
    fetch_miss(12'h000);
    refill(12'h000, d0, 4, -1, 0, -1);
    fetch_hit(12'h004, 32'h00100093);

    @(negedge clk);
    cpu_valid_i = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
